// File: rtl/arbitro_escrita_registradores.sv
// Register-file write-port arbiter.
// Three write requesters share the single register-file write port:
//   link (fixed target r31) > pipeline write-back > delayed load return,
// with a starvation escape that lifts the load return to top priority.
// A pending-load scoreboard tracks registers that still wait on memory
// and raises stall for RAW/WAW hazards seen in decode.
module arbitro_escrita_registradores #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        link_valid,
    input  logic [31:0] link_data,
    output logic        link_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);
    localparam logic [4:0] LINK_REG = 5'd31;

    logic [2:0]  starve_q, starve_d;
    logic [31:0] pending_q, pending_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;

    logic        link_gnt, wb_gnt, mem_gnt, mem_urgent;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic [31:0] set_vec, clr_vec;

    // Grant selection: starved load return first, then link > wb > mem.
    always_comb begin
        link_gnt   = 1'b0;
        wb_gnt     = 1'b0;
        mem_gnt    = 1'b0;
        mem_urgent = mem_valid && (starve_q == LIMIT);
        if (reset) begin
            mem_gnt = 1'b0;
        end else if (mem_urgent) begin
            mem_gnt = 1'b1;
        end else if (link_valid) begin
            link_gnt = 1'b1;
        end else if (wb_valid) begin
            wb_gnt = 1'b1;
        end else if (mem_valid) begin
            mem_gnt = 1'b1;
        end else begin
            mem_gnt = 1'b0;
        end
    end

    assign link_ready = link_gnt;
    assign wb_ready   = wb_gnt;
    assign mem_ready  = mem_gnt;

    // Write-port payload: r0 writes are accepted but never reach the file.
    always_comb begin
        sel_addr  = 5'd0;
        sel_data  = 32'd0;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (link_gnt) begin
            sel_addr = LINK_REG;
            sel_data = link_data;
        end else if (wb_gnt) begin
            sel_addr = wb_addr;
            sel_data = wb_data;
        end else if (mem_gnt) begin
            sel_addr = mem_addr;
            sel_data = mem_data;
        end else begin
            sel_addr = 5'd0;
            sel_data = 32'd0;
        end
        if ((link_gnt || wb_gnt || mem_gnt) && (sel_addr != 5'd0)) begin
            rf_we_d   = 1'b1;
            rf_addr_d = sel_addr;
            rf_data_d = sel_data;
        end else begin
            rf_we_d = 1'b0;
        end
    end

    // Starvation counter: counts denied load-return cycles, saturating.
    always_comb begin
        starve_d = 3'd0;
        if (mem_valid && !mem_gnt) begin
            if (starve_q >= LIMIT) begin
                starve_d = LIMIT;
            end else begin
                starve_d = starve_q + 3'd1;
            end
        end else begin
            starve_d = 3'd0;
        end
    end

    // Scoreboard update: a new issue wins over a same-cycle load return.
    always_comb begin
        set_vec   = 32'd0;
        clr_vec   = 32'd0;
        if (issue_valid && (issue_addr != 5'd0)) begin
            set_vec = 32'd1 << issue_addr;
        end else begin
            set_vec = 32'd0;
        end
        if (mem_gnt) begin
            clr_vec = 32'd1 << mem_addr;
        end else begin
            clr_vec = 32'd0;
        end
        pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
    end

    // Hazard detection against the current scoreboard contents.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            stall = 1'b0;
        end else begin
            stall = pending_q[rs_addr] | pending_q[rt_addr]
                  | (issue_valid & pending_q[issue_addr]);
        end
    end

    // State and registered write-port outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q  <= 3'd0;
            pending_q <= 32'd0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= 5'd0;
            rf_data_q <= 32'd0;
        end else begin
            starve_q  <= starve_d;
            pending_q <= pending_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_we   = rf_we_q;
    assign rf_addr = rf_addr_q;
    assign rf_data = rf_data_q;

endmodule
